// File: rtl/bitnet_pkg.sv
// rtl/bitnet_pkg.sv - shared types and helpers for the propagation sequencer
//
// Purpose: sequencer state encoding, settle-counter width and the layer
//          index width helper used by prop_sequencer and prop_strobe_gen.
// Ports:   none (package).
package bitnet_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FWD,
    S_TGT,
    S_BWD,
    S_NEXT,
    S_DONE
  } seq_state_t;

  // Settle gap is at most 15 idle cycles.
  localparam int SETTLE_W = 4;

  // A single-layer stack still needs a 1-bit index.
  function automatic int layer_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prop_sequencer_if.sv
// rtl/prop_sequencer_if.sv - sample/target handshakes and per-layer strobes
//
// Purpose: groups the source-facing handshakes and the unit-array strobes.
// Signals:
//   sample_valid_in / sample_ready_out : input-vector handshake (layer 0)
//   target_valid_in / target_ready_out : target/error handshake (last layer)
//   fd_prop_out / bk_prop_out          : one-hot forward/backward strobes
// Modports: slave = sequencer side, master = source/array side.
interface prop_sequencer_if #(
  parameter int NUM_LAYERS = 8
);

  logic                  sample_valid_in;
  logic                  sample_ready_out;
  logic                  target_valid_in;
  logic                  target_ready_out;
  logic [NUM_LAYERS-1:0] fd_prop_out;
  logic [NUM_LAYERS-1:0] bk_prop_out;

  modport slave (
    input  sample_valid_in,
    input  target_valid_in,
    output sample_ready_out,
    output target_ready_out,
    output fd_prop_out,
    output bk_prop_out
  );

  modport master (
    output sample_valid_in,
    output target_valid_in,
    input  sample_ready_out,
    input  target_ready_out,
    input  fd_prop_out,
    input  bk_prop_out
  );

endinterface

// File: rtl/prop_strobe_gen.sv
// rtl/prop_strobe_gen.sv - one-hot layer strobe walk with settle gaps
//
// Purpose: after a start pulse, walks a one-hot strobe across all layers
//          (ascending for forward, descending for backward). Each strobe
//          lasts one cycle and is followed by SETTLE_CYCLES idle cycles.
// Ports:
//   clk_in, rst_in  : clock, synchronous active-low reset
//   clear_in        : abandon the current walk (abort)
//   start_in        : begin a walk on the next cycle
//   dir_in          : 0 = layer 0 upward, 1 = last layer downward
//   strobe_out      : one-hot strobe, zero during settle gaps and when idle
//   sweep_done_out  : high on the final settle cycle of the last layer
module prop_strobe_gen
  import bitnet_pkg::*;
#(
  parameter int NUM_LAYERS    = 8,
  parameter int SETTLE_CYCLES = 0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  clear_in,
  input  logic                  start_in,
  input  logic                  dir_in,
  output logic [NUM_LAYERS-1:0] strobe_out,
  output logic                  sweep_done_out
);

  localparam int IDX_W = layer_idx_w(NUM_LAYERS);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_LAYERS - 1);
  localparam logic [SETTLE_W-1:0] GAP_END  = SETTLE_W'(SETTLE_CYCLES);

  logic                active;
  logic                dir;
  logic [IDX_W-1:0]    idx;
  logic [SETTLE_W-1:0] gap;
  logic [IDX_W-1:0]    end_idx;
  logic                gap_end;

  assign end_idx = dir ? '0 : LAST_IDX;
  // gap==GAP_END marks the last cycle spent on the current layer; with no
  // settle gap that is the strobe cycle itself.
  assign gap_end = (gap == GAP_END);

  assign sweep_done_out = active && gap_end && (idx == end_idx);

  always_comb begin
    strobe_out = '0;
    if (active && (gap == '0)) begin
      strobe_out = NUM_LAYERS'(1) << idx;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      active <= 1'b0;
      dir    <= 1'b0;
      idx    <= '0;
      gap    <= '0;
    end else if (clear_in) begin
      active <= 1'b0;
      gap    <= '0;
    end else if (start_in) begin
      active <= 1'b1;
      dir    <= dir_in;
      idx    <= dir_in ? LAST_IDX : '0;
      gap    <= '0;
    end else if (active) begin
      if (gap_end) begin
        gap <= '0;
        if (idx == end_idx) begin
          active <= 1'b0;
        end else if (dir) begin
          idx <= idx - IDX_W'(1);
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end else begin
        gap <= gap + SETTLE_W'(1);
      end
    end
  end

endmodule

// File: rtl/prop_sequencer.sv
// rtl/prop_sequencer.sv - forward/backward propagation sequencer for a unit stack
//
// Purpose: per training sample, accepts the input vector, sweeps fd_prop
//          over layers 0..N-1, accepts the target, sweeps bk_prop over
//          layers N-1..0, then toggles the oscillator and counts the sample.
//          After the programmed number of samples it pulses done_out.
// Ports:
//   clk_in, rst_in     : clock, synchronous active-low reset
//   start_in           : begin a run (IDLE only)
//   abort_in           : cancel the run, no done pulse
//   num_samples_in     : samples per run, latched at start
//   bus                : sample/target handshakes and layer strobes
//   oscillator_out     : oscillator bit, toggles after every sample
//   busy_out           : any state but IDLE
//   done_out           : one-cycle pulse at run completion
//   sample_count_out   : samples completed in this run
module prop_sequencer
  import bitnet_pkg::*;
#(
  parameter int NUM_LAYERS    = 8,
  parameter int SETTLE_CYCLES = 0,
  parameter int CNT_W         = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             abort_in,
  input  logic [CNT_W-1:0] num_samples_in,
  prop_sequencer_if.slave  bus,
  output logic             oscillator_out,
  output logic             busy_out,
  output logic             done_out,
  output logic [CNT_W-1:0] sample_count_out
);

  seq_state_t state;
  seq_state_t next_state;

  logic [CNT_W-1:0]      target_cnt;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_inc;
  logic                  osc;
  logic                  sample_hs;
  logic                  target_hs;
  logic [NUM_LAYERS-1:0] strobe;
  logic                  sweep_done;

  // Abort wins over a simultaneous handshake, so the ready signals are
  // withdrawn in that cycle and the transfer never happens.
  assign sample_hs = (state == S_LOAD) && bus.sample_valid_in && !abort_in;
  assign target_hs = (state == S_TGT) && bus.target_valid_in && !abort_in;
  assign count_inc = count + CNT_W'(1);

  prop_strobe_gen #(
    .NUM_LAYERS    (NUM_LAYERS),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_strobe (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .clear_in       (abort_in),
    .start_in       (sample_hs | target_hs),
    .dir_in         (target_hs),
    .strobe_out     (strobe),
    .sweep_done_out (sweep_done)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state           = state;
    bus.sample_ready_out = 1'b0;
    bus.target_ready_out = 1'b0;
    bus.fd_prop_out      = '0;
    bus.bk_prop_out      = '0;
    busy_out             = (state != S_IDLE);
    done_out             = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_in) begin
          next_state = (num_samples_in == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        bus.sample_ready_out = !abort_in;
        if (sample_hs) begin
          next_state = S_FWD;
        end
      end
      S_FWD: begin
        bus.fd_prop_out = strobe;
        if (sweep_done) begin
          next_state = S_TGT;
        end
      end
      S_TGT: begin
        bus.target_ready_out = !abort_in;
        if (target_hs) begin
          next_state = S_BWD;
        end
      end
      S_BWD: begin
        bus.bk_prop_out = strobe;
        if (sweep_done) begin
          next_state = S_NEXT;
        end
      end
      S_NEXT: begin
        next_state = (count_inc == target_cnt) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done_out   = 1'b1;
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase

    if (abort_in && (state != S_IDLE)) begin
      next_state = S_IDLE;
    end
  end

  // Count and oscillator survive abort and run completion; only reset and
  // an accepted start (count only) clear them.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      target_cnt <= '0;
      count      <= '0;
      osc        <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start_in) begin
        target_cnt <= num_samples_in;
        count      <= '0;
      end
      if ((state == S_NEXT) && !abort_in) begin
        count <= count_inc;
        osc   <= ~osc;
      end
    end
  end

  assign oscillator_out   = osc;
  assign sample_count_out = count;

endmodule

// File: tb/tb_prop_sequencer.sv
// tb/tb_prop_sequencer.sv - scoreboard bench for prop_sequencer (N=4, S=0 and S=2)
module tb_prop_sequencer;
  import bitnet_pkg::*;

  localparam int N  = 4;
  localparam int CW = 16;

  typedef struct packed {
    int          cyc;
    logic [3:0]  fd;
    logic [3:0]  bk;
    logic        sr;
    logic        tr;
    logic        dn;
    logic        osc;
    logic [15:0] cnt;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    start = 2'b00;
  logic [1:0]    abort = 2'b00;
  logic [CW-1:0] num [2];
  logic [1:0]    tvalid = 2'b00;
  logic          busy0, busy2, done0, done2, osc0, osc2;
  logic [CW-1:0] cnt0, cnt2;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  int   dly [2];
  int   w [2];
  logic [1:0] sr_p = 2'b00;
  logic [1:0] tr_p = 2'b00;
  ev_t  q0 [$];
  ev_t  q1 [$];

  prop_sequencer_if #(.NUM_LAYERS(N)) if0 ();
  prop_sequencer_if #(.NUM_LAYERS(N)) if2 ();

  assign if0.sample_valid_in = 1'b1;
  assign if2.sample_valid_in = 1'b1;
  assign if0.target_valid_in = tvalid[0];
  assign if2.target_valid_in = tvalid[1];

  prop_sequencer #(.NUM_LAYERS(N), .SETTLE_CYCLES(0), .CNT_W(CW)) dut0 (
    .clk_in(clk), .rst_in(rst), .start_in(start[0]), .abort_in(abort[0]),
    .num_samples_in(num[0]), .bus(if0), .oscillator_out(osc0),
    .busy_out(busy0), .done_out(done0), .sample_count_out(cnt0)
  );

  prop_sequencer #(.NUM_LAYERS(N), .SETTLE_CYCLES(2), .CNT_W(CW)) dut2 (
    .clk_in(clk), .rst_in(rst), .start_in(start[1]), .abort_in(abort[1]),
    .num_samples_in(num[1]), .bus(if2), .oscillator_out(osc2),
    .busy_out(busy2), .done_out(done2), .sample_count_out(cnt2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Target source: raises target_valid dly[d] cycles after target_ready rises.
  always @(posedge clk) begin
    #2;
    if (if0.target_ready_out) begin tvalid[0] = (w[0] >= dly[0]); w[0]++; end
    else begin tvalid[0] = 1'b0; w[0] = 0; end
    if (if2.target_ready_out) begin tvalid[1] = (w[1] >= dly[1]); w[1]++; end
    else begin tvalid[1] = 1'b0; w[1] = 0; end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic chk_idle(input int d, input string nm, input logic o, input logic [15:0] c);
    if (d == 0) begin
      chk({nm, "_ctl"}, 32'({busy0, done0, if0.sample_ready_out, if0.target_ready_out,
                             if0.fd_prop_out, if0.bk_prop_out}), 32'd0);
      chk({nm, "_osc"}, 32'(osc0), 32'(o));
      chk({nm, "_cnt"}, 32'(cnt0), 32'(c));
    end else begin
      chk({nm, "_ctl"}, 32'({busy2, done2, if2.sample_ready_out, if2.target_ready_out,
                             if2.fd_prop_out, if2.bk_prop_out}), 32'd0);
      chk({nm, "_osc"}, 32'(osc2), 32'(o));
      chk({nm, "_cnt"}, 32'(cnt2), 32'(c));
    end
  endtask

  task automatic push(input int d, input int c, input logic [3:0] fd, input logic [3:0] bk,
                      input logic sr, input logic tr, input logic dn, input logic o,
                      input logic [15:0] cn);
    ev_t e;
    e.cyc = c; e.fd = fd; e.bk = bk; e.sr = sr; e.tr = tr; e.dn = dn; e.osc = o; e.cnt = cn;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Expected events of one sample whose sample handshake is at cycle t.
  // nf/nb limit how many fd/bk strobes are expected (truncated by reset/abort).
  task automatic exp_sample(input int d, input int t, input int tdly, input bit last,
                            input logic ob, input logic [15:0] cb, input int nf,
                            input int nb, output int nxt);
    int s, tt, u;
    s  = (d == 0) ? 0 : 2;
    tt = t + 1 + N * (s + 1);
    u  = tt + tdly;
    push(d, t, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, ob, cb);
    for (int k = 0; k < nf; k++)
      push(d, t + 1 + k * (s + 1), 4'(1 << k), 4'b0, 1'b0, 1'b0, 1'b0, ob, cb);
    if (nf == N) begin
      push(d, tt, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, ob, cb);
      for (int j = N - 1; j >= N - nb; j--)
        push(d, u + 1 + (N - 1 - j) * (s + 1), 4'b0, 4'(1 << j), 1'b0, 1'b0, 1'b0, ob, cb);
    end
    nxt = u + 2 + N * (s + 1);
    if (last && nf == N && nb == N)
      push(d, nxt, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1, ~ob, cb + 16'd1);
  endtask

  task automatic observe(input int d, input logic [3:0] fd, input logic [3:0] bk,
                         input logic sr, input logic tr, input logic dn, input logic o,
                         input logic [15:0] c);
    ev_t got, e;
    bit  trig, miss;
    trig = (fd != 4'b0) || (bk != 4'b0) || dn || (sr && !sr_p[d]) || (tr && !tr_p[d]);
    sr_p[d] = sr;
    tr_p[d] = tr;
    if (trig) begin
      got.cyc = cyc; got.fd = fd; got.bk = bk; got.sr = sr; got.tr = tr;
      got.dn = dn; got.osc = o; got.cnt = c;
      miss = 1'b0;
      e = '0;
      if (d == 0) begin if (q0.size() == 0) miss = 1'b1; else e = q0.pop_front(); end
      else begin if (q1.size() == 0) miss = 1'b1; else e = q1.pop_front(); end
      n_checks++;
      if (miss || (got !== e)) begin
        n_fail++;
        $display("FAIL ev_dut%0d: got cyc=%0d fd=%b bk=%b sr=%b tr=%b dn=%b osc=%b cnt=%0d, required%s cyc=%0d fd=%b bk=%b sr=%b tr=%b dn=%b osc=%b cnt=%0d",
                 d, got.cyc, got.fd, got.bk, got.sr, got.tr, got.dn, got.osc, got.cnt,
                 miss ? " nothing, last" : "", e.cyc, e.fd, e.bk, e.sr, e.tr, e.dn, e.osc, e.cnt);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      observe(0, if0.fd_prop_out, if0.bk_prop_out, if0.sample_ready_out,
              if0.target_ready_out, done0, osc0, cnt0);
      observe(1, if2.fd_prop_out, if2.bk_prop_out, if2.sample_ready_out,
              if2.target_ready_out, done2, osc2, cnt2);
    end
  end

  task automatic start_run(input int d, input logic [15:0] n, output int t);
    num[d]   = n;
    start[d] = 1'b1;
    step();
    start[d] = 1'b0;
    t = cyc;
  endtask

  initial begin
    int t, nx, ab;
    logic o;
    num[0] = '0; num[1] = '0;
    dly[0] = 0;  dly[1] = 0;
    w[0] = 0;    w[1] = 0;

    // Reset state
    repeat (3) step();
    chk_idle(0, "reset0", 1'b0, 16'd0);
    chk_idle(1, "reset2", 1'b0, 16'd0);
    rst = 1'b1;
    mon_en = 1'b1;
    step();

    // A: S=0, one sample, valids immediate
    start_run(0, 16'd1, t);
    exp_sample(0, t, 0, 1'b1, 1'b0, 16'd0, N, N, nx);
    wait_until(nx + 1);
    chk_idle(0, "A_end", 1'b1, 16'd1);

    // B: S=2, one sample
    start_run(1, 16'd1, t);
    exp_sample(1, t, 0, 1'b1, 1'b0, 16'd0, N, N, nx);
    wait_until(nx + 1);
    chk_idle(1, "B_end", 1'b1, 16'd1);

    // Reset clears the oscillator
    rst = 1'b0;
    step();
    chk_idle(0, "rst_mid0", 1'b0, 16'd0);
    rst = 1'b1;
    step();

    // C: three samples, target delayed 5 cycles each
    dly[0] = 5;
    start_run(0, 16'd3, t);
    o = 1'b0;
    for (int s = 0; s < 3; s++) begin
      exp_sample(0, t, 5, (s == 2), o, 16'(s), N, N, nx);
      o = ~o;
      t = nx;
    end
    wait_until(t + 1);
    chk_idle(0, "C_end", 1'b1, 16'd3);
    dly[0] = 0;

    // D: zero-sample run
    start_run(0, 16'd0, t);
    push(0, t, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
    wait_until(t + 1);
    chk_idle(0, "D_end", 1'b1, 16'd0);

    // E: abort on bk_prop[2] of the second sample, then a clean rerun
    start_run(0, 16'd2, t);
    exp_sample(0, t, 0, 1'b0, 1'b1, 16'd0, N, N, nx);
    t = nx;
    exp_sample(0, t, 0, 1'b0, 1'b0, 16'd1, N, 2, nx);
    ab = t + 1 + N + 2;
    wait_until(ab);
    abort[0] = 1'b1;
    step();
    abort[0] = 1'b0;
    chk_idle(0, "E_abort", 1'b0, 16'd1);
    start_run(0, 16'd1, t);
    exp_sample(0, t, 0, 1'b1, 1'b0, 16'd0, N, N, nx);
    wait_until(nx + 1);
    chk_idle(0, "E_rerun", 1'b1, 16'd1);

    // F: start during a run is ignored; then reset mid-FWD
    start_run(0, 16'd1, t);
    exp_sample(0, t, 0, 1'b1, 1'b1, 16'd0, N, N, nx);
    wait_until(t + 2);
    num[0]   = 16'd7;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    wait_until(nx + 1);
    chk_idle(0, "F_ign", 1'b0, 16'd1);
    start_run(0, 16'd2, t);
    exp_sample(0, t, 0, 1'b0, 1'b0, 16'd0, N, N, nx);
    t = nx;
    exp_sample(0, t, 0, 1'b0, 1'b1, 16'd1, 2, 0, nx);
    wait_until(t + 2);
    rst = 1'b0;
    step();
    chk_idle(0, "F_rst", 1'b0, 16'd0);
    rst = 1'b1;
    repeat (5) step();

    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
